alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Multi-cycle issue/writeback controller that drives the 2-bit-op ALU (ops: 00 zero, 01 add, 10 or, 11 zero) and consumes its result.
- Accepts one 32-bit LoongArch instruction per handshake.
- Decodes add.w, or, addi.w, ori and lu12i.w; reads the register file; issues operands and op to the ALU; writes the result back.
- Sits between the fetch stage and the ALU/register file.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.
- RA_W, 5, register address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  instruction available
- instr_ready  out  1  controller can accept an instruction
- instr  in  32  instruction word
- rf_raddr1  out  RA_W  read address for rj
- rf_raddr2  out  RA_W  read address for rk
- rf_rdata1  in  XLEN  combinational read data for port 1
- rf_rdata2  in  XLEN  combinational read data for port 2
- alu_a  out  XLEN  ALU operand a
- alu_b  out  XLEN  ALU operand b
- alu_op  out  2  ALU operation code
- alu_result  in  XLEN  combinational ALU result
- rf_we  out  1  register write enable
- rf_waddr  out  RA_W  register write address
- rf_wdata  out  XLEN  register write data
- done  out  1  one-cycle pulse: instruction retired
- illegal  out  1  one-cycle pulse, qualifies done: instruction undecodable

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; instruction register=0.
  - alu_a, alu_b, rf_wdata = 0; alu_op = 2'b00; rf_we, done, illegal = 0.
  - rf_raddr1/2 and rf_waddr = 0.
  - Reset mid-operation aborts the instruction with no register write.
- FSM states: IDLE, DECODE, EXEC, WB.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready, latch instr and go to DECODE.
  - instr_ready=0 in all other states. No buffering: a single instruction is in flight.
- DECODE:
  - rf_raddr1=instr[9:5], rf_raddr2=instr[14:10].
  - Decode and register alu_a/alu_b/alu_op as listed below, then go to EXEC.
  - add.w (instr[31:15]=17'h00020): a=rdata1, b=rdata2, op=01.
  - or (instr[31:15]=17'h0002A): a=rdata1, b=rdata2, op=10.
  - addi.w (instr[31:22]=10'h00A): a=rdata1, b=sign-extended instr[21:10], op=01.
  - ori (instr[31:22]=10'h00E): a=rdata1, b=zero-extended instr[21:10], op=10.
  - lu12i.w (instr[31:25]=7'h0A): a=0, b={instr[24:5],12'h000}, op=01.
  - Any other encoding: done=1 and illegal=1 this cycle, alu_op held at 00, no write, return to IDLE.
- EXEC:
  - alu_a/alu_b/alu_op stay stable.
  - Capture alu_result into rf_wdata; go to WB.
- WB:
  - rf_waddr=instr[4:0].
  - rf_we=1 only if rd!=0; writes to r0 are suppressed but still retire.
  - done=1; go to IDLE.
- Latency:
  - Accept edge at cycle 0; WB (done) occupies cycle 3. Throughput is 1 instruction per 4 cycles.
  - Illegal instruction: done at cycle 1.
- Timing of outputs:
  - rf_we, done, illegal and instr_ready are decoded from registered state only; no combinational path from instr_valid.
  - alu_a/alu_b/alu_op/rf_wdata hold their last values when idle.
- Arithmetic: add wraps modulo 2^32; there is no overflow flag.

Decomposition:
- Shared package holds:
  - ALU op constants: ALU_ZERO=2'b00, ALU_ADD=2'b01, ALU_OR=2'b10.
  - Opcode match constants for the five instructions.
  - The FSM state enum.
- Natural sub-module: alu_issue_decode, combinational. Maps instr to {legal, uses_rk, imm_sel, alu_op, rd}. The FSM and operand registers stay in alu_issue_ctrl.

Test Plan:
- add.w r3,r1,r2 (0x00100823), r1=5, r2=7 -> alu_op=01, a=5, b=7; done at cycle 3 with rf_we=1, waddr=3, wdata=0x0000000C.
- ori r4,r1,0xF0 (0x0383C024), r1=0x100 -> alu_op=10, b=0x000000F0, wdata=0x000001F0.
- addi.w r5,r1,-1 (0x02BFFC25), r1=0 -> b=0xFFFFFFFF, wdata=0xFFFFFFFF. Also r1=0xFFFFFFFF with imm=1 -> wdata=0 (wrap).
- lu12i.w r6,0x12345 (0x142468A6) -> a=0, b=0x12345000, wdata=0x12345000, waddr=6.
- add.w r0,r1,r2 (0x00100820) -> done pulses, rf_we stays 0. Illegal 0xFFFFFFFF -> done=illegal=1 at cycle 1, no write, instr_ready=1 at cycle 2.
- Back-to-back: instr_valid held high -> second accept exactly 4 cycles after the first. rst_n low during EXEC -> rf_we never asserts, all outputs at reset values, instr_ready=1 after release.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg: shared ALU op codes, opcode match values, FSM state and decode record
package alu_issue_ctrl_pkg;
  localparam int XLEN = 32;
  localparam int RA_W = 5;
  localparam logic [1:0] ALU_ZERO = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_OR = 2'b10;
  localparam logic [16:0] OPC_ADD_W = 17'h00020;
  localparam logic [16:0] OPC_OR = 17'h0002A;
  localparam logic [9:0] OPC_ADDI_W = 10'h00A;
  localparam logic [9:0] OPC_ORI = 10'h00E;
  localparam logic [6:0] OPC_LU12I_W = 7'h0A;
  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;
  typedef enum logic [1:0] {IMM_SEXT, IMM_ZEXT, IMM_LUI} imm_sel_t;
  typedef struct packed {
    logic legal;
    logic uses_rk;
    imm_sel_t imm_sel;
    logic [1:0] alu_op;
    logic [4:0] rd;
    logic [4:0] rj;
    logic [4:0] rk;
    logic [11:0] imm12;
    logic [19:0] imm20;
  } dec_t;
endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: fetch handshake, register file and ALU signals of the issue controller
interface alu_issue_ctrl_if #(parameter int XLEN = 32, parameter int RA_W = 5);
  logic instr_valid;
  logic instr_ready;
  logic [31:0] instr;
  logic [RA_W-1:0] rf_raddr1;
  logic [RA_W-1:0] rf_raddr2;
  logic [XLEN-1:0] rf_rdata1;
  logic [XLEN-1:0] rf_rdata2;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [1:0] alu_op;
  logic [XLEN-1:0] alu_result;
  logic rf_we;
  logic [RA_W-1:0] rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic done;
  logic illegal;
  modport master (
    input instr_valid, instr, rf_rdata1, rf_rdata2, alu_result,
    output instr_ready, rf_raddr1, rf_raddr2, alu_a, alu_b, alu_op, rf_we, rf_waddr, rf_wdata, done, illegal
  );
  modport slave (
    output instr_valid, instr, rf_rdata1, rf_rdata2, alu_result,
    input instr_ready, rf_raddr1, rf_raddr2, alu_a, alu_b, alu_op, rf_we, rf_waddr, rf_wdata, done, illegal
  );
endinterface

// File: rtl/alu_issue_ctrl_decode.sv
// alu_issue_decode: combinational LoongArch decode of add.w/or/addi.w/ori/lu12i.w into operand selects
module alu_issue_decode
  import alu_issue_ctrl_pkg::*;
(
  input logic [31:0] instr,
  output dec_t dec
);
  logic is_add, is_or, is_addi, is_ori, is_lu;
  assign is_add = instr[31:15] == OPC_ADD_W;
  assign is_or = instr[31:15] == OPC_OR;
  assign is_addi = instr[31:22] == OPC_ADDI_W;
  assign is_ori = instr[31:22] == OPC_ORI;
  assign is_lu = instr[31:25] == OPC_LU12I_W;
  // field extraction and per-instruction operand selection
  always_comb begin
    dec.legal = is_add | is_or | is_addi | is_ori | is_lu;
    dec.uses_rk = is_add | is_or;
    dec.imm_sel = is_ori ? IMM_ZEXT : is_lu ? IMM_LUI : IMM_SEXT;
    dec.alu_op = (is_add | is_addi | is_lu) ? ALU_ADD : (is_or | is_ori) ? ALU_OR : ALU_ZERO;
    dec.rd = instr[4:0];
    dec.rj = instr[9:5];
    dec.rk = instr[14:10];
    dec.imm12 = instr[21:10];
    dec.imm20 = instr[24:5];
  end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: four-state issue/writeback controller feeding a 2-bit-op ALU from the register file
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input logic clk,
  input logic rst_n,
  alu_issue_ctrl_if.master bus
);
  state_t state;
  logic [31:0] ir;
  dec_t dec;
  logic [XLEN-1:0] imm, op_a, op_b;
  alu_issue_decode u_dec (.instr(ir), .dec(dec));
  assign imm = dec.imm_sel == IMM_ZEXT ? {{(XLEN-12){1'b0}}, dec.imm12}
             : dec.imm_sel == IMM_LUI ? {dec.imm20, 12'h000}
             : {{(XLEN-12){dec.imm12[11]}}, dec.imm12};
  assign op_a = dec.imm_sel == IMM_LUI ? '0 : bus.rf_rdata1;
  assign op_b = dec.uses_rk ? bus.rf_rdata2 : imm;
  assign bus.rf_raddr1 = dec.rj;
  assign bus.rf_raddr2 = dec.rk;
  assign bus.rf_waddr = dec.rd;
  assign bus.instr_ready = state == IDLE;
  assign bus.illegal = state == DECODE && !dec.legal;
  assign bus.done = state == WB || bus.illegal;
  assign bus.rf_we = state == WB && dec.rd != '0;
  // FSM plus operand and writeback registers; ALU operands hold between instructions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ir <= '0;
      bus.alu_a <= '0;
      bus.alu_b <= '0;
      bus.alu_op <= ALU_ZERO;
      bus.rf_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (bus.instr_valid) begin
          ir <= bus.instr;
          state <= DECODE;
        end
        DECODE: if (dec.legal) begin
          bus.alu_a <= op_a;
          bus.alu_b <= op_b;
          bus.alu_op <= dec.alu_op;
          state <= EXEC;
        end else begin
          bus.alu_op <= ALU_ZERO;
          state <= IDLE;
        end
        EXEC: begin
          bus.rf_wdata <= bus.alu_result;
          state <= WB;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: randomized and directed checks of the issue controller against an instruction-level model
module tb_alu_issue_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.XLEN(32), .RA_W(5)) bus ();
  alu_issue_ctrl #(.XLEN(32), .RA_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [31:0] mem [32];
  logic [31:0] exp_rf [32];
  logic load_en = 1'b0;
  logic [4:0] load_addr = '0;
  logic [31:0] load_data = '0;
  int we_count = 0;
  int checks = 0;
  int errors = 0;

  assign bus.rf_rdata1 = mem[bus.rf_raddr1];
  assign bus.rf_rdata2 = mem[bus.rf_raddr2];
  assign bus.alu_result = bus.alu_op == 2'b01 ? bus.alu_a + bus.alu_b
                        : bus.alu_op == 2'b10 ? (bus.alu_a | bus.alu_b) : 32'h0;

  always @(posedge clk) begin
    if (bus.rf_we) begin
      mem[bus.rf_waddr] <= bus.rf_wdata;
      we_count <= we_count + 1;
    end else if (load_en) mem[load_addr] <= load_data;
  end

  function automatic void model(input logic [31:0] ins, output bit lg, output logic [1:0] op,
                                output logic [31:0] a, output logic [31:0] b, output logic [31:0] r,
                                output logic [4:0] rd);
    logic [31:0] s1, s2;
    s1 = exp_rf[ins[9:5]];
    s2 = exp_rf[ins[14:10]];
    lg = 1;
    rd = ins[4:0];
    a = s1;
    if (ins[31:15] == 17'h00020) begin op = 1; b = s2; end
    else if (ins[31:15] == 17'h0002A) begin op = 2; b = s2; end
    else if (ins[31:22] == 10'h00A) begin op = 1; b = 32'($signed(ins[21:10])); end
    else if (ins[31:22] == 10'h00E) begin op = 2; b = {20'h0, ins[21:10]}; end
    else if (ins[31:25] == 7'h0A) begin op = 1; a = 0; b = {ins[24:5], 12'h000}; end
    else begin lg = 0; op = 0; b = 0; end
    r = op == 1 ? a + b : a | b;
  endfunction

  task automatic set_reg(input logic [4:0] idx, input logic [31:0] val);
    @(negedge clk);
    load_en = 1'b1;
    load_addr = idx;
    load_data = val;
    @(posedge clk);
    #1 load_en = 1'b0;
    exp_rf[idx] = val;
  endtask

  task automatic run_instr(input logic [31:0] ins, input string name);
    bit lg;
    logic [1:0] op;
    logic [31:0] a, b, r;
    logic [4:0] rd;
    model(ins, lg, op, a, b, r, rd);
    @(negedge clk);
    checks++;
    if (bus.instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before: got %b exp 1", name, bus.instr_ready);
    end
    bus.instr_valid = 1'b1;
    bus.instr = ins;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    bus.instr = $urandom;
    @(negedge clk);
    checks++;
    if ({bus.done, bus.illegal, bus.rf_we, bus.instr_ready} !== {!lg, !lg, 2'b00}) begin
      errors++;
      $display("FAIL %s cycle1: got done=%b illegal=%b we=%b ready=%b exp done=%b illegal=%b we=0 ready=0",
               name, bus.done, bus.illegal, bus.rf_we, bus.instr_ready, !lg, !lg);
    end
    if (!lg) begin
      @(negedge clk);
      checks++;
      if ({bus.instr_ready, bus.done, bus.rf_we, bus.alu_op} !== {3'b100, 2'b00}) begin
        errors++;
        $display("FAIL %s illegal_after: got ready=%b done=%b we=%b op=%b exp ready=1 done=0 we=0 op=00",
                 name, bus.instr_ready, bus.done, bus.rf_we, bus.alu_op);
      end
      return;
    end
    @(negedge clk);
    checks++;
    if ({bus.alu_op, bus.alu_a, bus.alu_b, bus.done} !== {op, a, b, 1'b0}) begin
      errors++;
      $display("FAIL %s exec: got op=%b a=%h b=%h done=%b exp op=%b a=%h b=%h done=0",
               name, bus.alu_op, bus.alu_a, bus.alu_b, bus.done, op, a, b);
    end
    @(negedge clk);
    checks++;
    if ({bus.done, bus.illegal, bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {2'b10, rd != 5'd0, rd, r}) begin
      errors++;
      $display("FAIL %s wb: got done=%b illegal=%b we=%b waddr=%0d wdata=%h exp done=1 illegal=0 we=%b waddr=%0d wdata=%h",
               name, bus.done, bus.illegal, bus.rf_we, bus.rf_waddr, bus.rf_wdata, rd != 5'd0, rd, r);
    end
    if (rd != 5'd0) exp_rf[rd] = r;
    @(negedge clk);
    checks++;
    if ({bus.instr_ready, bus.done, bus.rf_we, bus.alu_op, bus.alu_a, bus.alu_b, bus.rf_wdata} !== {3'b100, op, a, b, r}) begin
      errors++;
      $display("FAIL %s idle_hold: got ready=%b done=%b we=%b op=%b a=%h b=%h wdata=%h exp ready=1 done=0 we=0 op=%b a=%h b=%h wdata=%h",
               name, bus.instr_ready, bus.done, bus.rf_we, bus.alu_op, bus.alu_a, bus.alu_b, bus.rf_wdata, op, a, b, r);
    end
  endtask

  task automatic test_reset();
    bus.instr_valid = 1'b0;
    bus.instr = 32'h0;
    #12;
    checks++;
    if ({bus.rf_we, bus.done, bus.illegal, bus.alu_op, bus.alu_a, bus.alu_b, bus.rf_wdata,
         bus.rf_raddr1, bus.rf_raddr2, bus.rf_waddr, bus.instr_ready} !== {5'b0, 96'h0, 15'h0, 1'b1}) begin
      errors++;
      $display("FAIL reset_values: got we=%b done=%b ill=%b op=%b a=%h b=%h wd=%h ra1=%0d ra2=%0d wa=%0d ready=%b exp all zero ready=1",
               bus.rf_we, bus.done, bus.illegal, bus.alu_op, bus.alu_a, bus.alu_b, bus.rf_wdata,
               bus.rf_raddr1, bus.rf_raddr2, bus.rf_waddr, bus.instr_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_rf[0] = 32'h0;
    for (int i = 0; i < 32; i++) set_reg(5'(i), 32'h0);
  endtask

  task automatic test_directed();
    set_reg(1, 32'd5);
    set_reg(2, 32'd7);
    run_instr(32'h00100823, "add_w");
    set_reg(1, 32'h100);
    run_instr(32'h0383C024, "ori");
    set_reg(1, 32'h0);
    run_instr(32'h02BFFC25, "addi_neg");
    set_reg(1, 32'hFFFFFFFF);
    run_instr(32'h02800425, "addi_wrap");
    run_instr(32'h142468A6, "lu12i_w");
    run_instr(32'h00100820, "add_r0");
    run_instr(32'hFFFFFFFF, "illegal");
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [4:0] rd, rj, rk;
    for (int i = 0; i < 60; i++) begin
      if (i % 6 == 0) set_reg(5'($urandom_range(1, 31)), $urandom);
      rd = 5'($urandom);
      rj = 5'($urandom);
      rk = 5'($urandom);
      case ($urandom_range(0, 5))
        0: ins = {17'h00020, rk, rj, rd};
        1: ins = {17'h0002A, rk, rj, rd};
        2: ins = {10'h00A, 12'($urandom), rj, rd};
        3: ins = {10'h00E, 12'($urandom), rj, rd};
        4: ins = {7'h0A, 20'($urandom), rd};
        default: ins = $urandom;
      endcase
      run_instr(ins, "random");
    end
  endtask

  task automatic test_back_to_back();
    int cyc_first, cyc_second;
    bit lg;
    logic [1:0] op;
    logic [31:0] a, b, r;
    logic [4:0] rd;
    cyc_first = -1;
    cyc_second = -1;
    set_reg(1, 32'h11);
    set_reg(2, 32'h22);
    model(32'h00100823, lg, op, a, b, r, rd);
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr = 32'h00100823;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.instr_ready && cyc_first < 0) cyc_first = i;
      else if (bus.instr_ready && cyc_second < 0) begin
        cyc_second = i;
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        break;
      end
    end
    bus.instr_valid = 1'b0;
    exp_rf[3] = r;
    checks++;
    if (cyc_first != 0 || cyc_second - cyc_first != 4) begin
      errors++;
      $display("FAIL back_to_back: got accepts at %0d and %0d exp spacing 4 starting at 0", cyc_first, cyc_second);
    end
    repeat (5) @(negedge clk);
    run_instr(32'h00100C64, "after_b2b");
  endtask

  task automatic test_reset_mid();
    int we_before;
    set_reg(1, 32'h1);
    set_reg(2, 32'h2);
    we_before = we_count;
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr = 32'h00100827;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.rf_we, bus.done, bus.illegal, bus.alu_op, bus.alu_a, bus.alu_b, bus.rf_wdata,
         bus.rf_raddr1, bus.rf_raddr2, bus.rf_waddr} !== {5'b0, 96'h0, 15'h0}) begin
      errors++;
      $display("FAIL reset_mid_values: got we=%b done=%b ill=%b op=%b a=%h b=%h wd=%h ra1=%0d ra2=%0d wa=%0d exp all zero",
               bus.rf_we, bus.done, bus.illegal, bus.alu_op, bus.alu_a, bus.alu_b, bus.rf_wdata,
               bus.rf_raddr1, bus.rf_raddr2, bus.rf_waddr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (we_count != we_before || bus.instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_abort: got writes=%0d ready=%b exp writes=0 ready=1", we_count - we_before, bus.instr_ready);
    end
    run_instr(32'h001008E7, "after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
